// File: rtl/actor_queue.sv
// rtl/actor_queue.sv - first-word fall-through token queue between two dataflow actors
// Optional protocol checking on ERR is enabled with ACTOR_QUEUE_ERR_CHECK_EN.
module actor_queue #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   In_SEND,
    input  logic [DATA_WIDTH-1:0]  In_DATA,
    input  logic [COUNT_WIDTH-1:0] In_COUNT,
    output logic                   In_RDY,
    output logic                   In_ACK,
    output logic                   Out_SEND,
    output logic [DATA_WIDTH-1:0]  Out_DATA,
    output logic [COUNT_WIDTH-1:0] Out_COUNT,
    input  logic                   Out_ACK,
    output logic                   ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    state_t                  state;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           occ;
    logic [CW-1:0]           occ_next;
    logic                    in_rdy_q;
    logic                    wr_en;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign wr_en = In_SEND & in_rdy_q;
    assign rd_en = Out_ACK & Out_SEND;

    always_comb begin
        occ_next = occ;
        case ({wr_en, rd_en})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    // State is re-derived from the next occupancy so In_RDY reacts one edge after a slot frees.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            occ      <= occ_next;
            in_rdy_q <= (occ_next != CW'(DEPTH));
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            if (occ_next == '0)
                state <= EMPTY;
            else if (occ_next == CW'(DEPTH))
                state <= FULL;
            else
                state <= PARTIAL;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= In_DATA;
    end

    assign In_RDY    = in_rdy_q;
    assign In_ACK    = wr_en;
    assign Out_SEND  = (state != EMPTY);
    assign Out_DATA  = Out_SEND ? mem[rd_ptr] : '0;
    assign Out_COUNT = COUNT_WIDTH'(occ);

`ifdef ACTOR_QUEUE_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            err_q <= 1'b0;
        else if ((In_SEND && !in_rdy_q) || (Out_ACK && !Out_SEND) ||
                 (wr_en && In_COUNT != COUNT_WIDTH'(1)))
            err_q <= 1'b1;
    end

    assign ERR = err_q;
`else
    logic unused_in_count;

    assign unused_in_count = ^In_COUNT;
    assign ERR = 1'b0;
`endif

endmodule
